hpdmc_ddr_rdcapture: RTL and testbench
======================================

// Module: hpdmc_ddr_rdcapture
// PURPOSE
//  Read-data capture stage behind the per-bit IDDR2 bank of the DDR SDRAM controller (HPDMC).
//  Takes the rising/falling half-words (q0/q1) in the sys_clk domain.
//  Delays each read command by a programmable CAS/round-trip latency.
//  Frames each burst into 2*DQ_WIDTH words with valid/last strobes for the data path.
//  Flags overlapping bursts.
// PARAMETERS
//  DQ_WIDTH     16  DQ pins; q0/q1 width
//  BURST_CYCLES 2   sys_clk cycles per read burst (BL4 on DDR = 2); must be >= 1
//  LAT_W        3   width of rd_lat; token pipeline depth = 2**LAT_W
// PORTS
//  sys_clk     in   1           system clock; all logic on rising edge
//  sys_rst     in   1           synchronous, active-high reset
//  q0          in   DQ_WIDTH    IDDR rising-edge half-word (first beat)
//  q1          in   DQ_WIDTH    IDDR falling-edge half-word (second beat)
//  read_cmd    in   1           1-cycle pulse: READ issued to SDRAM this cycle
//  rd_lat      in   LAT_W       cycles from read_cmd to first valid q0/q1 sample; 0 treated as 1
//  clear_err   in   1           clears overrun
//  data_out    out  2*DQ_WIDTH  captured word, {q0,q1} (q0 in MSBs)
//  data_valid  out  1           data_out holds a burst word this cycle
//  data_last   out  1           final word of a burst (qualified by data_valid)
//  busy        out  1           token in flight or burst in progress
//  overrun     out  1           sticky: burst start collided with an active burst
// BEHAVIOUR
//  Reset: all outputs 0, token pipeline cleared, FSM=IDLE.
//  - Reset mid-burst aborts the burst: no data_last is issued and in-flight tokens are lost.
//  Token pipeline: read_cmd shifts a 1 into a 2**LAT_W-deep shift register each cycle.
//  - Tap index L=max(rd_lat,1)-1 yields the start event.
//  - Start fires L cycles after the read_cmd cycle, i.e. q0/q1 are sampled rd_lat cycles after read_cmd.
//  - Output registered: data_valid asserts rd_lat+1 cycles after read_cmd.
//  - rd_lat is quasi-static; a change while busy=1 re-targets in-flight tokens (may drop or duplicate them).
//  FSM: IDLE, BURST; beat counter cnt (clog2(BURST_CYCLES) bits, min 1 bit).
//  - IDLE + start -> BURST, cnt=0, capture word.
//  - BURST: capture each cycle; cnt increments.
//  - At cnt==BURST_CYCLES-1, data_last=1 next cycle; then -> IDLE, or stay in BURST with cnt=0 if start coincides (seamless).
//  - BURST_CYCLES=1: every start is a single-word burst with data_last=1.
//  Collision: start while BURST and cnt!=BURST_CYCLES-1 -> start dropped, overrun<=1, current burst continues.
//  data_out holds its last value when data_valid=0 (not zeroed).
//  busy = |pipeline | (state==BURST); combinational from registers.
//  overrun: clear_err clears it; a new collision in the same cycle as clear_err wins (set).
// CONFIGURATION
//  HPDMC_RDCAP_SWAP_EN defined: adds input port half_swap (1 bit, quasi-static).
//  - half_swap=1: each word is {q1 of previous cycle, q0 of current cycle}.
//  - Corrects half-cycle DQS/clock skew; uses a DQ_WIDTH register of q1 updated every cycle, also reset to 0.
//  - Latency and framing are unchanged; half_swap=0 gives default ordering.
//  Not defined: half_swap port absent; data_out={q0,q1} always.
// TESTING
//  1 rd_lat=3, BURST_CYCLES=2, read_cmd @t0, q0/q1 = 16'hA1A1/16'hB1B1 @t3 and 16'hA2A2/16'hB2B2 @t4
//    -> valid @t4 data 32'hA1A1B1B1, valid+last @t5 data 32'hA2A2B2B2; busy t1..t4, 0 @t5.
//  2 read_cmd @t0 and @t2, rd_lat=2 -> four consecutive valid words t3..t6, last @t4 and @t6, no gap, overrun=0.
//  3 read_cmd @t0 and @t1, rd_lat=2 -> two words only (t3,t4), overrun=1 from t3.
//    - clear_err @t6 -> overrun=0 @t7.
//  4 rd_lat=0 vs rd_lat=1 with identical stimulus -> identical output timing (valid at t2).
//  5 sys_rst pulsed at the first valid word of a burst -> next cycle all outputs 0, busy=0, no last.
//    - Following read_cmd behaves as test 1.
//  6 SWAP_EN, half_swap=1, q1=16'h1111 @t3, q0=16'h2222 @t4, rd_lat=4
//    -> word @t5 = 32'h11112222.

Source files
------------

// File: rtl/hpdmc_ddr_rdcapture.sv
// HPDMC read-data capture: delays read commands by rd_lat and frames IDDR q0/q1 into burst words.
// Optional HPDMC_RDCAP_SWAP_EN adds half_swap to pair the previous cycle's q1 with the current q0.
module hpdmc_ddr_rdcapture #(
  parameter int DQ_WIDTH     = 16,
  parameter int BURST_CYCLES = 2,
  parameter int LAT_W        = 3
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [DQ_WIDTH-1:0]   q0,
  input  logic [DQ_WIDTH-1:0]   q1,
  input  logic                  read_cmd,
  input  logic [LAT_W-1:0]      rd_lat,
  input  logic                  clear_err,
`ifdef HPDMC_RDCAP_SWAP_EN
  input  logic                  half_swap,
`endif
  output logic [2*DQ_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  data_last,
  output logic                  busy,
  output logic                  overrun
);

  localparam int DEPTH = 2**LAT_W;
  localparam int CNT_W = (BURST_CYCLES > 1) ? $clog2(BURST_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_CYCLES - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [DEPTH-1:0]        pipe_q, pipe_d;
  logic [2*DQ_WIDTH-1:0]   data_q;
  logic                    valid_q, last_q, ovr_q;
  logic [LAT_W-1:0]        tap;
  logic                    start, collide, last_beat;
  logic [DQ_WIDTH-1:0]     hi_half, lo_half;
  logic [2*DQ_WIDTH-1:0]   word;

  function automatic logic [2*DQ_WIDTH-1:0] frame_word(input logic [DQ_WIDTH-1:0] hi,
                                                       input logic [DQ_WIDTH-1:0] lo);
    return {hi, lo};
  endfunction

`ifdef HPDMC_RDCAP_SWAP_EN
  logic [DQ_WIDTH-1:0] q1_prev_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) q1_prev_q <= '0;
    else         q1_prev_q <= q1;
  end

  always_comb begin
    hi_half = half_swap ? q1_prev_q : q0;
    lo_half = half_swap ? q0 : q1;
  end
`else
  always_comb begin
    hi_half = q0;
    lo_half = q1;
  end
`endif

  // Token tap: index 0 is read_cmd itself; a token is consumed where it is tapped.
  always_comb begin
    tap       = (rd_lat == '0) ? '0 : rd_lat - 1'b1;
    start     = (tap == '0) ? read_cmd : pipe_q[tap - 1'b1];
    last_beat = (state_q == BURST) && (cnt_q == CNT_LAST);
    collide   = start && (state_q == BURST) && (cnt_q != CNT_LAST);
    word      = frame_word(hi_half, lo_half);
    pipe_d    = '0;
    pipe_d[0] = read_cmd && (tap != '0);
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1] && (tap != LAT_W'(i));
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pipe_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      pipe_q  <= pipe_d;
      valid_q <= (state_q == BURST);
      last_q  <= last_beat;
      if (state_q == BURST) data_q <= word;
      if (collide)        ovr_q <= 1'b1;
      else if (clear_err) ovr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= BURST;
            cnt_q   <= '0;
          end
        end
        BURST: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (!start) state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign data_last  = last_q;
  assign overrun    = ovr_q;
  assign busy       = (|pipe_q) || (state_q == BURST);

endmodule

// File: tb/tb_hpdmc_ddr_rdcapture.sv
// Bench for hpdmc_ddr_rdcapture: directed scenarios plus random traffic against an interval-based burst model.
// Build with +define+HPDMC_RDCAP_SWAP_EN to cover the half_swap port.
module tb_hpdmc_ddr_rdcapture;
  localparam int DQ = 16;
  localparam int BC = 2;
  localparam int LW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, rc, clr;
  logic [DQ-1:0]   q0v, q1v;
  logic [LW-1:0]   lat;
  logic [2*DQ-1:0] dout;
  logic            dv, dl, bsy, ovr;
`ifdef HPDMC_RDCAP_SWAP_EN
  logic            hs;
`endif

  hpdmc_ddr_rdcapture #(.DQ_WIDTH(DQ), .BURST_CYCLES(BC), .LAT_W(LW)) dut (
    .sys_clk(clk), .sys_rst(rst), .q0(q0v), .q1(q1v), .read_cmd(rc), .rd_lat(lat),
    .clear_err(clr),
`ifdef HPDMC_RDCAP_SWAP_EN
    .half_swap(hs),
`endif
    .data_out(dout), .data_valid(dv), .data_last(dl), .busy(bsy), .overrun(ovr)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: start cycles in a queue, active burst as a [first,last] capture interval.
  int            cyc = 0;
  int            pend[$];
  int            cap_first = 1, cap_last = 0;
  logic          m_v = 0, m_l = 0, m_busy = 0, m_ov = 0;
  logic [2*DQ-1:0] m_data = '0;
  logic [DQ-1:0] m_q1p = '0;
  logic          n_v, n_l, n_busy, n_ov;
  logic [2*DQ-1:0] n_data;
  logic [DQ-1:0] n_q1p;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s @cyc%0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_eval();
    int   L;
    logic st, capt, sw;
    sw = 1'b0;
`ifdef HPDMC_RDCAP_SWAP_EN
    sw = hs;
`endif
    if (rst) begin
      pend.delete();
      cap_first = 1; cap_last = 0;
      n_v = 0; n_l = 0; n_busy = 0; n_ov = 0; n_data = '0; n_q1p = '0;
    end else begin
      L = (lat == 0) ? 0 : int'(lat) - 1;
      if (L > 0 && rc) pend.push_back(cyc + L);
      st = 1'b0;
      if (L == 0) st = rc;
      else if (pend.size() > 0 && pend[0] == cyc) begin
        st = 1'b1;
        void'(pend.pop_front());
      end
      capt   = (cyc >= cap_first) && (cyc <= cap_last);
      n_v    = capt;
      n_l    = capt && (cyc == cap_last);
      n_data = capt ? (sw ? {m_q1p, q0v} : {q0v, q1v}) : m_data;
      n_ov   = m_ov;
      if (st && capt && cyc != cap_last) n_ov = 1'b1;
      else begin
        if (clr) n_ov = 1'b0;
        if (st) begin
          cap_first = cyc + 1;
          cap_last  = cyc + BC;
        end
      end
      n_busy = (pend.size() > 0) || ((cyc + 1 >= cap_first) && (cyc + 1 <= cap_last));
      n_q1p  = q1v;
    end
    cyc++;
  endtask

  task automatic step();
    model_eval();
    @(posedge clk);
    #1;
    m_v = n_v; m_l = n_l; m_busy = n_busy; m_ov = n_ov; m_data = n_data; m_q1p = n_q1p;
    chk("valid", {63'd0, dv}, {63'd0, m_v});
    chk("last", {63'd0, dl}, {63'd0, m_l});
    chk("busy", {63'd0, bsy}, {63'd0, m_busy});
    chk("overrun", {63'd0, ovr}, {63'd0, m_ov});
    chk("data", {32'd0, dout}, {32'd0, m_data});
  endtask

  task automatic do_reset();
    rst = 1'b1; rc = 1'b0; clr = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic run_t1(input string tag);
    lat = 3;
    rc = 1'b1; step();
    chk({tag, "_busy_t1"}, {63'd0, bsy}, 64'd1);
    rc = 1'b0; step(); step();
    q0v = 16'hA1A1; q1v = 16'hB1B1; step();
    chk({tag, "_v_t4"}, {63'd0, dv}, 64'd1);
    chk({tag, "_l_t4"}, {63'd0, dl}, 64'd0);
    chk({tag, "_d_t4"}, {32'd0, dout}, 64'h A1A1B1B1);
    q0v = 16'hA2A2; q1v = 16'hB2B2; step();
    chk({tag, "_v_t5"}, {63'd0, dv}, 64'd1);
    chk({tag, "_l_t5"}, {63'd0, dl}, 64'd1);
    chk({tag, "_d_t5"}, {32'd0, dout}, 64'h A2A2B2B2);
    chk({tag, "_busy_t5"}, {63'd0, bsy}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; rc = 1'b0; clr = 1'b0; lat = 3; q0v = '0; q1v = '0;
`ifdef HPDMC_RDCAP_SWAP_EN
    hs = 1'b0;
`endif
    step(); step();
    chk("rst_valid", {63'd0, dv}, 64'd0);
    chk("rst_busy", {63'd0, bsy}, 64'd0);
    chk("rst_data", {32'd0, dout}, 64'd0);
    rst = 1'b0;

    run_t1("t1");

    // Reset on the first valid word, then a clean repeat
    do_reset();
    lat = 3;
    rc = 1'b1; step();
    rc = 1'b0; step(); step();
    q0v = 16'h1234; q1v = 16'h5678; step();
    chk("t5_v_pre", {63'd0, dv}, 64'd1);
    rst = 1'b1; step();
    rst = 1'b0;
    chk("t5_v", {63'd0, dv}, 64'd0);
    chk("t5_l", {63'd0, dl}, 64'd0);
    chk("t5_busy", {63'd0, bsy}, 64'd0);
    chk("t5_d", {32'd0, dout}, 64'd0);
    run_t1("t5r");

    // Back-to-back bursts
    do_reset();
    lat = 2;
    rc = 1'b1; step();
    rc = 1'b0; step();
    rc = 1'b1; step();
    rc = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("t2_v", {63'd0, dv}, 64'd1);
      chk("t2_l", {63'd0, dl}, (k % 2 == 1) ? 64'd1 : 64'd0);
      chk("t2_ov", {63'd0, ovr}, 64'd0);
      if (k < 3) step();
    end

    // Colliding bursts and overrun clear
    do_reset();
    lat = 2;
    rc = 1'b1; step(); step();
    rc = 1'b0; step();
    chk("t3_ov_t3", {63'd0, ovr}, 64'd1);
    step(); step(); step();
    chk("t3_ov_t6", {63'd0, ovr}, 64'd1);
    clr = 1'b1; step();
    clr = 1'b0;
    chk("t3_ov_t7", {63'd0, ovr}, 64'd0);

    // rd_lat 0 and 1 behave the same
    for (int l = 0; l < 2; l++) begin
      do_reset();
      lat = LW'(l);
      rc = 1'b1; step();
      rc = 1'b0;
      chk("t4_v_t1", {63'd0, dv}, 64'd0);
      step();
      chk("t4_v_t2", {63'd0, dv}, 64'd1);
    end

`ifdef HPDMC_RDCAP_SWAP_EN
    do_reset();
    hs = 1'b1; lat = 4;
    rc = 1'b1; step();
    rc = 1'b0; step(); step();
    q1v = 16'h1111; q0v = 16'h0000; step();
    q0v = 16'h2222; q1v = 16'h3333; step();
    chk("t6_d", {32'd0, dout}, 64'h 11112222);
    chk("t6_v", {63'd0, dv}, 64'd1);
`endif

    // Random traffic across every rd_lat
    for (int p = 0; p < 8; p++) begin
      do_reset();
      lat = LW'(p);
`ifdef HPDMC_RDCAP_SWAP_EN
      hs = 1'($urandom_range(0, 1));
`endif
      for (int n = 0; n < 150; n++) begin
        rc  = ($urandom_range(0, 2) == 0);
        clr = ($urandom_range(0, 15) == 0);
        rst = ($urandom_range(0, 199) == 0);
        q0v = DQ'($urandom);
        q1v = DQ'($urandom);
        step();
      end
      rst = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
